mul_scheduler: RTL and testbench



---
 rtl/mul_sched_pkg.sv | 34 +++
 rtl/mul_sched_fifo.sv | 51 +++++
 rtl/mul_scheduler.sv | 146 ++++++++++++++
 tb/tb_mul_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_sched_pkg.sv
// Shared types and helpers for the multiplier scheduler: tag/response
// structs and the round-robin pick function.
package mul_sched_pkg;
  localparam int MUL_LAT_DEFAULT = 4;
  localparam int MAX_REQ         = 8;
  localparam int ID_W            = 3;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            hi;
  } mul_tag_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
  } rsp_entry_t;

  // Returns {found, index}: first set bit of vld at or after ptr, wrapping mod n.
  function automatic logic [ID_W:0] rr_pick(input logic [MAX_REQ-1:0] vld,
                                            input logic [ID_W-1:0]    ptr,
                                            input int                 n);
    logic [ID_W:0] r;
    int            idx;
    r = '0;
    for (int k = MAX_REQ-1; k >= 0; k--) begin
      if (k < n) begin
        idx = (int'(ptr) + k) % n;
        if (vld[idx[ID_W-1:0]]) r = {1'b1, idx[ID_W-1:0]};
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/mul_sched_fifo.sv
// Synchronous FIFO with occupancy count; output reads zero while empty.
module mul_sched_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == ($clog2(DEPTH+1))'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/mul_scheduler.sv
// Round-robin scheduler sharing one fixed-latency 32x32 multiplier between NREQ
// requesters with credit-protected responses. Define MUL_SCHED_PERF_EN for perf counters.
import mul_sched_pkg::*;

module mul_scheduler #(
  parameter int NREQ      = 4,
  parameter int MUL_LAT   = MUL_LAT_DEFAULT,
  parameter int RSP_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0][31:0]     req_s,
  input  logic [NREQ-1:0][31:0]     req_t,
  input  logic [NREQ-1:0]           req_is_signed,
  input  logic [NREQ-1:0]           req_hi,
  output logic                      mul_enable,
  output logic                      mul_is_signed,
  output logic [31:0]               mul_s,
  output logic [31:0]               mul_t,
  input  logic                      mul_completed,
  input  logic [63:0]               mul_d,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [31:0]               rsp_data
`ifdef MUL_SCHED_PERF_EN
  ,
  output logic [31:0]               perf_issue,
  output logic [31:0]               perf_credit_stall
`endif
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(RSP_DEPTH+1);

  logic [IDW-1:0]     ptr, win;
  logic [MAX_REQ-1:0] vld_pad;
  logic [ID_W-1:0]    ptr_pad;
  logic [ID_W:0]      pick;
  logic [CW-1:0]      fifo_count, inflight;
  logic [CW:0]        used;
  logic               credit, issue;
  mul_tag_t           tag_pipe [MUL_LAT];
  mul_tag_t           head, new_tag;
  rsp_entry_t         push_ent, rsp_ent;
  logic               push, pop, fifo_empty, fifo_full;

  always_comb begin
    vld_pad = '0;
    vld_pad[NREQ-1:0] = req_valid;
    ptr_pad = '0;
    ptr_pad[IDW-1:0] = ptr;
  end

  assign pick   = rr_pick(vld_pad, ptr_pad, NREQ);
  assign win    = pick[IDW-1:0];
  // Every in-flight product already owns a FIFO slot, so a full count blocks issue.
  assign used   = {1'b0, fifo_count} + {1'b0, inflight};
  assign credit = used < (CW+1)'(RSP_DEPTH);
  assign issue  = rstn && pick[ID_W] && credit;

  always_comb begin
    req_ready     = '0;
    mul_s         = '0;
    mul_t         = '0;
    mul_is_signed = 1'b0;
    if (issue) begin
      req_ready[win] = 1'b1;
      mul_s          = req_s[win];
      mul_t          = req_t[win];
      mul_is_signed  = req_is_signed[win];
    end
  end
  assign mul_enable = issue;

  always_comb begin
    new_tag       = '0;
    new_tag.valid = issue;
    new_tag.id    = ID_W'(win);
    new_tag.hi    = issue && req_hi[win];
  end
  assign head = tag_pipe[MUL_LAT-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr      <= '0;
      inflight <= '0;
      for (int k = 0; k < MUL_LAT; k++) tag_pipe[k] <= '0;
    end else begin
      if (issue) ptr <= (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
      tag_pipe[0] <= new_tag;
      for (int k = 1; k < MUL_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
      case ({issue, head.valid})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: ;
      endcase
    end
  end

  // A done pulse without a valid head tag is stale (multiplier is not reset) and dropped.
  assign push          = head.valid;
  assign push_ent.id   = head.id;
  assign push_ent.data = head.hi ? mul_d[63:32] : mul_d[31:0];
  assign pop           = !fifo_empty && rsp_ready;

  mul_sched_fifo #(
    .WIDTH($bits(rsp_entry_t)),
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (push),
    .push_data(push_ent),
    .pop      (pop),
    .pop_data (rsp_ent),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_id    = rsp_ent.id[IDW-1:0];
  assign rsp_data  = rsp_ent.data;

`ifdef MUL_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_issue        <= '0;
      perf_credit_stall <= '0;
    end else begin
      if (issue && perf_issue != '1) perf_issue <= perf_issue + 1'b1;
      if (|req_valid && !credit && perf_credit_stall != '1)
        perf_credit_stall <= perf_credit_stall + 1'b1;
    end
  end
`endif

  logic unused_bits;
  assign unused_bits = ^{pick, rsp_ent.id, fifo_full, mul_completed};

  a_head_done: assert property (@(posedge clk) disable iff (!rstn) head.valid |-> mul_completed);
  a_no_ovf:    assert property (@(posedge clk) disable iff (!rstn) push |-> (!fifo_full || pop));
  a_onehot:    assert property (@(posedge clk) disable iff (!rstn) $onehot0(req_ready));
endmodule

// File: tb/tb_mul_scheduler.sv
// Directed bench for mul_scheduler with a fixed-latency multiplier model.
module tb_mul_scheduler;
  localparam int NREQ = 4, MUL_LAT = 4, RSP_DEPTH = 8;

  logic                  clk = 1'b0, rstn = 1'b0;
  logic [NREQ-1:0]       req_valid = '0, req_ready, req_is_signed = '0, req_hi = '0;
  logic [NREQ-1:0][31:0] req_s = '0, req_t = '0;
  logic                  mul_enable, mul_is_signed, mul_completed;
  logic [31:0]           mul_s, mul_t;
  logic [63:0]           mul_d;
  logic                  rsp_valid, rsp_ready = 1'b0;
  logic [1:0]            rsp_id;
  logic [31:0]           rsp_data;
`ifdef MUL_SCHED_PERF_EN
  logic [31:0]           perf_issue, perf_credit_stall;
`endif
  int checks = 0, errors = 0;

  mul_scheduler #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_s(req_s), .req_t(req_t), .req_is_signed(req_is_signed), .req_hi(req_hi),
    .mul_enable(mul_enable), .mul_is_signed(mul_is_signed), .mul_s(mul_s), .mul_t(mul_t),
    .mul_completed(mul_completed), .mul_d(mul_d),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
`ifdef MUL_SCHED_PERF_EN
    , .perf_issue(perf_issue), .perf_credit_stall(perf_credit_stall)
`endif
  );

  always #5 clk = ~clk;

  // Multiplier model: no reset, completes exactly MUL_LAT cycles after enable.
  logic [MUL_LAT-1:0]       mp_v = '0;
  logic [MUL_LAT-1:0][63:0] mp_d = '0;

  function automatic logic [63:0] model_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic sg);
    if (sg) return $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    return {32'b0, a} * {32'b0, b};
  endfunction

  always @(posedge clk) begin
    mp_v <= {mp_v[MUL_LAT-2:0], mul_enable};
    mp_d <= {mp_d[MUL_LAT-2:0], model_mul(mul_s, mul_t, mul_is_signed)};
  end
  assign mul_completed = mp_v[MUL_LAT-1];
  assign mul_d         = mp_d[MUL_LAT-1];

  task automatic clear_inputs();
    req_valid = '0; req_s = '0; req_t = '0; req_is_signed = '0; req_hi = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs(); rsp_ready = 1'b0; rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
    checks++; if (mul_enable !== 1'b0) begin errors++; $display("FAIL reset_mul_enable got %b want 0", mul_enable); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_single();
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      clear_inputs();
      if (c == 0) begin req_valid[0] = 1'b1; req_s[0] = 32'd3; req_t[0] = 32'd5; end
      rsp_ready = (c == 5);
      #1;
      if (c == 0) begin
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant got %b want 0001", req_ready); end
        checks++; if (mul_enable !== 1'b1 || mul_s !== 32'd3 || mul_t !== 32'd5 || mul_is_signed !== 1'b0) begin
          errors++; $display("FAIL single_issue got en=%b s=%h t=%h sg=%b want en=1 s=3 t=5 sg=0", mul_enable, mul_s, mul_t, mul_is_signed); end
      end
      if (c == 1) begin
        checks++; if (mul_enable !== 1'b0 || mul_s !== 32'h0) begin
          errors++; $display("FAIL single_idle got en=%b s=%h want en=0 s=0", mul_enable, mul_s); end
      end
      if (c == 4) begin
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early got %b want 0", rsp_valid); end
      end
      if (c == 5) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'h0000000F) begin
          errors++; $display("FAIL single_rsp got v=%b id=%0d d=%h want v=1 id=0 d=0000000f", rsp_valid, rsp_id, rsp_data); end
      end
      if (c == 6) begin
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drained got %b want 0", rsp_valid); end
      end
    end
  endtask

  task automatic test_hi_lo();
    logic [1:0]  exp_id [3]   = '{2'd1, 2'd2, 2'd2};
    logic [31:0] exp_d  [3]   = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    logic [3:0]  exp_g  [3]   = '{4'b0010, 4'b0100, 4'b0100};
    rsp_ready = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      clear_inputs();
      if (c == 0) begin
        req_valid[1] = 1'b1; req_s[1] = 32'hFFFFFFFE; req_t[1] = 32'd3;
        req_is_signed[1] = 1'b1; req_hi[1] = 1'b1;
      end
      if (c == 1 || c == 2) begin
        req_valid[2] = 1'b1; req_s[2] = 32'hFFFFFFFF; req_t[2] = 32'hFFFFFFFF;
        req_hi[2] = (c == 1);
      end
      #1;
      if (c <= 2) begin
        checks++; if (req_ready !== exp_g[c]) begin errors++; $display("FAIL hilo_grant%0d got %b want %b", c, req_ready, exp_g[c]); end
      end
      if (c == 0) begin
        checks++; if (mul_is_signed !== 1'b1) begin errors++; $display("FAIL hilo_signed got %b want 1", mul_is_signed); end
      end
      if (c >= 5 && c <= 7) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id[c-5] || rsp_data !== exp_d[c-5]) begin
          errors++; $display("FAIL hilo_rsp%0d got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                             c-5, rsp_valid, rsp_id, rsp_data, exp_id[c-5], exp_d[c-5]); end
      end
      if (c == 8) begin
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL hilo_drained got %b want 0", rsp_valid); end
      end
    end
  endtask

  task automatic test_all_four();
    do_reset();
    rsp_ready = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      clear_inputs();
      if (c < 5) begin
        req_valid = 4'hF;
        for (int i = 0; i < NREQ; i++) begin req_s[i] = 32'(i + 1); req_t[i] = 32'h10; end
      end
      #1;
      if (c < 5) begin
        checks++; if (req_ready !== 4'(1 << (c % 4)) || mul_s !== 32'((c % 4) + 1)) begin
          errors++; $display("FAIL rr_grant%0d got rdy=%b s=%h want rdy=%b s=%h",
                             c, req_ready, mul_s, 4'(1 << (c % 4)), 32'((c % 4) + 1)); end
      end else if (c < 10) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'((c - 5) % 4) || rsp_data !== 32'((((c - 5) % 4) + 1) * 16)) begin
          errors++; $display("FAIL rr_rsp%0d got v=%b id=%0d d=%h want v=1 id=%0d d=%h", c - 5,
                             rsp_valid, rsp_id, rsp_data, (c - 5) % 4, 32'((((c - 5) % 4) + 1) * 16)); end
      end else begin
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_drained got %b want 0", rsp_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    int exp_bp [8] = '{2, 3, 4, 5, 6, 7, 8, 22};
    logic grant;
    do_reset();
    for (int c = 0; c <= 27; c++) begin
      @(negedge clk);
      clear_inputs();
      req_valid[0] = 1'b1; req_s[0] = 32'(c + 1); req_t[0] = 32'd1;
      rsp_ready = (c == 20);
      #1;
      grant = (c <= 7) || (c == 21);
      checks++; if (req_ready !== {3'b0, grant}) begin
        errors++; $display("FAIL bp_grant%0d got %b want %b", c, req_ready, {3'b0, grant}); end
      if (grant) begin
        checks++; if (mul_s !== 32'(c + 1)) begin errors++; $display("FAIL bp_oper%0d got %h want %h", c, mul_s, 32'(c + 1)); end
      end
      if (c == 19) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd1) begin
          errors++; $display("FAIL bp_head got v=%b d=%h want v=1 d=1", rsp_valid, rsp_data); end
      end
`ifdef MUL_SCHED_PERF_EN
      if (c == 20) begin
        checks++; if (perf_issue !== 32'd8) begin errors++; $display("FAIL perf_issue got %0d want 8", perf_issue); end
        checks++; if (perf_credit_stall !== 32'd12) begin errors++; $display("FAIL perf_stall got %0d want 12", perf_credit_stall); end
      end
      if (c == 22) begin
        checks++; if (perf_issue !== 32'd9) begin errors++; $display("FAIL perf_issue2 got %0d want 9", perf_issue); end
      end
`endif
    end
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      clear_inputs();
      rsp_ready = 1'b1;
      #1;
      if (c < 8) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'(exp_bp[c])) begin
          errors++; $display("FAIL bp_drain%0d got v=%b id=%0d d=%h want v=1 id=0 d=%h",
                             c, rsp_valid, rsp_id, rsp_data, 32'(exp_bp[c])); end
      end else begin
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", rsp_valid); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int stale_rsp = 0;
    rsp_ready = 1'b0;
    for (int c = 0; c <= 18; c++) begin
      @(negedge clk);
      clear_inputs();
      if (c <= 2) begin req_valid[0] = 1'b1; req_s[0] = 32'd7; req_t[0] = 32'd7; end
      if (c == 3) rstn = 1'b0;
      if (c == 4) rstn = 1'b1;
      if (c == 12) begin req_valid[3] = 1'b1; req_s[3] = 32'd6; req_t[3] = 32'd7; end
      if (c >= 12) rsp_ready = 1'b1;
      #1;
      if (c <= 2) begin
        checks++; if (req_ready !== 4'b0001 || mul_enable !== 1'b1) begin
          errors++; $display("FAIL mid_issue%0d got rdy=%b en=%b want rdy=0001 en=1", c, req_ready, mul_enable); end
      end
      if (c >= 3 && c <= 11 && rsp_valid !== 1'b0) stale_rsp++;
      if (c == 12) begin
        checks++; if (stale_rsp !== 0) begin errors++; $display("FAIL mid_stale got %0d responses want 0", stale_rsp); end
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL mid_regrant got %b want 1000", req_ready); end
      end
      if (c == 17) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 32'd42) begin
          errors++; $display("FAIL mid_rsp got v=%b id=%0d d=%h want v=1 id=3 d=2a", rsp_valid, rsp_id, rsp_data); end
      end
      if (c == 18) begin
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_drained got %b want 0", rsp_valid); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_hi_lo();
    test_all_four();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
